// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - multi-cycle shifter/rotator, STEP bits per cycle.
// Define SHIFT_ROTATE_EN to build rotate-left/right selected by i_rot.
module shift_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [SW-1:0]   i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_op_alt,
  input  logic            i_rot,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
  localparam logic [SW:0] XLEN_W = (SW+1)'(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SW-1:0]   rem_q, rem_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic            f_left, f_right, accept;
  logic [SW-1:0]   amt;
  logic [SW:0]     inv_amt;
  logic [XLEN-1:0] shifted;

`ifdef SHIFT_ROTATE_EN
  logic            rot_q, rot_d;
`else
  logic            unused_rot;
  assign unused_rot = i_rot;
`endif

  always_comb begin
    f_left  = (i_funct3 == 3'b001);
    f_right = (i_funct3 == 3'b101);
    accept  = i_start && (f_left || f_right) && (state_q != SHIFT) && !i_kill;

    // the last partial step covers amounts that are not a multiple of STEP
    if ({1'b0, rem_q} < STEP_W) amt = rem_q;
    else                        amt = STEP_W[SW-1:0];
    inv_amt = XLEN_W - {1'b0, amt};

    if (left_q)       shifted = acc_q << amt;
    else if (arith_q) shifted = XLEN'($signed(acc_q) >>> amt);
    else              shifted = acc_q >> amt;
`ifdef SHIFT_ROTATE_EN
    if (rot_q) begin
      if (left_q) shifted = (acc_q << amt) | (acc_q >> inv_amt);
      else        shifted = (acc_q >> amt) | (acc_q << inv_amt);
    end
`endif

    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    left_d  = left_q;
    arith_d = arith_q;
`ifdef SHIFT_ROTATE_EN
    rot_d   = rot_q;
`endif

    if (i_kill) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (state_q == SHIFT) begin
      acc_d = shifted;
      rem_d = rem_q - amt;
      if (rem_d == '0) state_d = DONE;
    end else if (accept) begin
      acc_d   = i_in_a;
      rem_d   = i_in_b;
      left_d  = f_left;
`ifdef SHIFT_ROTATE_EN
      rot_d   = i_rot;
      arith_d = f_right && i_op_alt && !i_rot;
`else
      arith_d = f_right && i_op_alt;
`endif
      state_d = (i_in_b == '0) ? DONE : SHIFT;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      left_q  <= left_d;
      arith_q <= arith_d;
`ifdef SHIFT_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign o_result = acc_q;
  assign o_busy   = (state_q == SHIFT);
  assign o_done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed checks for shift_unit (XLEN=32/STEP=4 and XLEN=64/STEP=1).
module tb_shift_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic        start32, kill32, alt32, rot32;
  logic [31:0] a32;
  logic [4:0]  b32;
  logic [2:0]  f32;
  logic [31:0] res32;
  logic        busy32, done32;

  logic        start64, kill64, alt64, rot64;
  logic [63:0] a64;
  logic [5:0]  b64;
  logic [2:0]  f64;
  logic [63:0] res64;
  logic        busy64, done64;

  shift_unit #(.XLEN(32), .STEP(4)) dut32 (
    .i_clk_n(clk), .i_rst(rst), .i_start(start32), .i_kill(kill32),
    .i_in_a(a32), .i_in_b(b32), .i_funct3(f32), .i_op_alt(alt32), .i_rot(rot32),
    .o_result(res32), .o_busy(busy32), .o_done(done32)
  );

  shift_unit #(.XLEN(64), .STEP(1)) dut64 (
    .i_clk_n(clk), .i_rst(rst), .i_start(start64), .i_kill(kill64),
    .i_in_a(a64), .i_in_b(b64), .i_funct3(f64), .i_op_alt(alt64), .i_rot(rot64),
    .o_result(res64), .o_busy(busy64), .o_done(done64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op32(input logic [31:0] a, input logic [4:0] b, input logic [2:0] f3,
                          input logic alt, input logic rot,
                          output logic [31:0] res, output int lat, output int busy_n);
    @(negedge clk);
    a32 = a; b32 = b; f32 = f3; alt32 = alt; rot32 = rot; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1; busy_n = 0;
    while (!done32 && lat < 200) begin
      if (busy32) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    res = res32;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start32 = 0; kill32 = 0; alt32 = 0; rot32 = 0; a32 = '0; b32 = '0; f32 = '0;
    start64 = 0; kill64 = 0; alt64 = 0; rot64 = 0; a64 = '0; b64 = '0; f64 = '0;
    #12;
    total++;
    if (res32 !== 32'h0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++;
      $display("FAIL reset32: result=%h busy=%b done=%b, required 0/0/0", res32, busy32, done32);
    end
    total++;
    if (res64 !== 64'h0 || busy64 !== 1'b0 || done64 !== 1'b0) begin
      bad++;
      $display("FAIL reset64: result=%h busy=%b done=%b, required 0/0/0", res64, busy64, done64);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sll;
    logic [31:0] r; int lat; int bn;
    run_op32(32'h1, 5'd5, 3'b001, 1'b0, 1'b0, r, lat, bn);
    total++;
    if (r !== 32'h20) begin bad++; $display("FAIL sll_result: got %h, required 00000020", r); end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL sll_latency: got %0d, required 3", lat); end
    total++;
    if (bn !== 2) begin bad++; $display("FAIL sll_busy_cycles: got %0d, required 2", bn); end
  endtask

  task automatic test_shift_right;
    logic [31:0] r; int lat; int bn;
    run_op32(32'h80000000, 5'd31, 3'b101, 1'b1, 1'b0, r, lat, bn);
    total++;
    if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL sra_result: got %h, required ffffffff", r); end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL sra_latency: got %0d, required 9", lat); end
    run_op32(32'h80000000, 5'd31, 3'b101, 1'b0, 1'b0, r, lat, bn);
    total++;
    if (r !== 32'h00000001) begin bad++; $display("FAIL srl_result: got %h, required 00000001", r); end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL srl_latency: got %0d, required 9", lat); end
    run_op32(32'hF0000000, 5'd6, 3'b101, 1'b1, 1'b0, r, lat, bn);
    total++;
    if (r !== 32'hFFC00000) begin bad++; $display("FAIL sra6_result: got %h, required ffc00000", r); end
  endtask

  task automatic test_zero_amount;
    logic [31:0] r; int lat; int bn;
    logic [2:0] f3s [3] = '{3'b001, 3'b101, 3'b101};
    logic       alts [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_op32(32'hDEADBEEF, 5'd0, f3s[i], alts[i], 1'b0, r, lat, bn);
      total++;
      if (r !== 32'hDEADBEEF || lat !== 1 || bn !== 0) begin
        bad++;
        $display("FAIL zero_amount[%0d]: result=%h lat=%0d busy=%0d, required deadbeef/1/0", i, r, lat, bn);
      end
    end
  endtask

  task automatic test_ignore_start_and_reset;
    int lat; int seen;
    @(negedge clk);
    a32 = 32'h1; b32 = 5'd8; f32 = 3'b001; alt32 = 0; rot32 = 0; start32 = 1'b1;
    @(posedge clk); #1;
    a32 = 32'hFFFF; b32 = 5'd1; f32 = 3'b101; alt32 = 1'b1;
    lat = 1;
    @(posedge clk); #1;
    start32 = 1'b0; lat++;
    while (!done32 && lat < 200) begin @(posedge clk); #1; lat++; end
    total++;
    if (res32 !== 32'h100 || lat !== 3) begin
      bad++;
      $display("FAIL ignore_start: result=%h lat=%0d, required 00000100/3", res32, lat);
    end
    @(negedge clk);
    a32 = 32'h1; b32 = 5'd8; f32 = 3'b001; alt32 = 0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (res32 !== 32'h0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_shift: result=%h busy=%b done=%b, required 0/0/0", res32, busy32, done32);
    end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done32) seen++; end
    @(negedge clk);
    rst = 1'b0;
    a32 = 32'h3; b32 = 5'd0; f32 = 3'b001; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    total++;
    if (seen !== 0 || done32 !== 1'b1 || res32 !== 32'h3) begin
      bad++;
      $display("FAIL first_accept_after_reset: stray_done=%0d done=%b result=%h, required 0/1/00000003", seen, done32, res32);
    end
  endtask

  task automatic test_kill_and_illegal;
    int seen;
    @(negedge clk);
    a32 = 32'h1; b32 = 5'd8; f32 = 3'b001; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; kill32 = 1'b1;
    @(posedge clk); #1;
    kill32 = 1'b0;
    seen = 0;
    if (busy32) seen++;
    repeat (4) begin if (done32) seen++; @(posedge clk); #1; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL kill_in_shift: busy/done cycles=%0d, required 0", seen); end
    @(negedge clk);
    start32 = 1'b1; kill32 = 1'b1; b32 = 5'd0;
    @(posedge clk); #1;
    start32 = 1'b0; kill32 = 1'b0;
    total++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      bad++;
      $display("FAIL kill_over_start: done=%b busy=%b, required 0/0", done32, busy32);
    end
    @(negedge clk);
    start32 = 1'b1; f32 = 3'b000; b32 = 5'd4;
    @(posedge clk); #1;
    start32 = 1'b0;
    total++;
    if (done32 !== 1'b0 || busy32 !== 1'b0) begin
      bad++;
      $display("FAIL illegal_funct3: done=%b busy=%b, required 0/0", done32, busy32);
    end
  endtask

  task automatic test_rotate;
    logic [31:0] r; int lat; int bn;
    logic [31:0] exp_r;
`ifdef SHIFT_ROTATE_EN
    exp_r = 32'h80000000;
`else
    exp_r = 32'h00000000;
`endif
    run_op32(32'h1, 5'd1, 3'b101, 1'b0, 1'b1, r, lat, bn);
    total++;
    if (r !== exp_r || lat !== 2) begin
      bad++;
      $display("FAIL rotate_right: result=%h lat=%0d, required %h/2", r, lat, exp_r);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a64 = 64'h1; b64 = 6'd63; f64 = 3'b001; alt64 = 0; rot64 = 0; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    lat = 1;
    while (!done64 && lat < 200) begin @(posedge clk); #1; lat++; end
    total++;
    if (res64 !== 64'h8000000000000000 || lat !== 64) begin
      bad++;
      $display("FAIL sll64: result=%h lat=%0d, required 8000000000000000/64", res64, lat);
    end
    a64 = 64'h5; b64 = 6'd2; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    total++;
    if (busy64 !== 1'b1) begin bad++; $display("FAIL back_to_back_busy: got %b, required 1", busy64); end
    lat = 1;
    while (!done64 && lat < 200) begin @(posedge clk); #1; lat++; end
    total++;
    if (res64 !== 64'h14 || lat !== 3) begin
      bad++;
      $display("FAIL back_to_back_result: result=%h lat=%0d, required 0000000000000014/3", res64, lat);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_sll();
    test_shift_right();
    test_zero_amount();
    test_ignore_start_and_reset();
    test_kill_and_illegal();
    test_rotate();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter STEP, default 1, bits shifted per cycle; power of two, 1..XLEN.
REQ-003 Parameter SW, default $clog2(XLEN), shift-amount width; derived, SHALL not be overridden.
REQ-004 i_clk_n  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  reset; asynchronous, active-high.
REQ-006 i_start  in  1  operation request, sampled on clock edge.
REQ-007 i_kill  in  1  synchronous abort of the operation in flight.
REQ-008 i_in_a  in  XLEN  operand to shift.
REQ-009 i_in_b  in  SW  shift amount; wider sources SHALL be truncated by the caller.
REQ-010 i_funct3  in  3  001 = left, 101 = right; other codes are not operations.
REQ-011 i_op_alt  in  1  with funct3 101: 1 = arithmetic, 0 = logical.
REQ-012 i_rot  in  1  rotate select; see Configuration.
REQ-013 o_result  out  XLEN  result, valid when o_done = 1, held until the next accept.
REQ-014 o_busy  out  1  high while in SHIFT.
REQ-015 o_done  out  1  one-cycle pulse marking o_result valid.

Function
REQ-016 States SHALL be IDLE, SHIFT and DONE, and o_busy SHALL equal (state == SHIFT).
REQ-017 Accept = i_start && funct3 in {001,101} && state in {IDLE,DONE} && !i_kill; otherwise i_start SHALL be ignored.
REQ-018 On accept: latch operand, amount, op; go to DONE if amount == 0, else to SHIFT.
REQ-019 In SHIFT, each cycle shift by min(STEP, remaining) and decrement remaining by the same; go to DONE when remaining reaches 0.
REQ-020 Latency: o_done SHALL rise ceil(amount/STEP)+1 cycles after the accept edge (amount 0: 1 cycle).
REQ-021 DONE SHALL last one cycle, then go to IDLE unless a new accept occurs in the same cycle (back-to-back accept from DONE).
REQ-022 Left shift SHALL fill with 0; logical right with 0; arithmetic right with the latched bit XLEN-1.
REQ-023 i_start in SHIFT SHALL be ignored, and latched operands SHALL not change.
REQ-024 i_kill SHALL force IDLE with no o_done pulse; kill has priority over a simultaneous start.
REQ-025 i_in_a, i_in_b, i_funct3, i_op_alt and i_rot SHALL only be sampled on accept.

Reset
REQ-026 While i_rst = 1: state = IDLE, o_result = 0, o_busy = 0, o_done = 0, and the remaining count = 0.
REQ-027 Reset mid-operation SHALL abandon the operation immediately with no o_done pulse.
REQ-028 The first accept SHALL be possible on the first rising edge after i_rst deasserts.

Configuration
REQ-029 The macro SHIFT_ROTATE_EN, when defined, SHALL enable rotate: i_rot = 1 with funct3 001 = rotate-left, with funct3 101 = rotate-right (i_op_alt ignored).
REQ-030 Rotate SHALL use the same per-cycle STEP schedule and latency as shifts.
REQ-031 Without SHIFT_ROTATE_EN, i_rot SHALL be ignored, no rotate logic SHALL be built, and behaviour SHALL be as if i_rot = 0.

Verification (XLEN=32, STEP=4 unless stated)
REQ-032 SLL a=0x00000001, b=5 -> o_result 0x00000020, o_done 3 cycles after accept, o_busy high 2 cycles.
REQ-033 SRA a=0x80000000, b=31 -> 0xFFFFFFFF after 9 cycles; SRL same inputs -> 0x00000001.
REQ-034 Any op with b=0, a=0xDEADBEEF -> 0xDEADBEEF, o_done 1 cycle after accept, o_busy never high.
REQ-035 Start SLL b=8; pulse i_start with new operands in the first SHIFT cycle -> ignored, first result correct; then i_rst mid-SHIFT -> no o_done, outputs 0.
REQ-036 With SHIFT_ROTATE_EN, ROR a=0x00000001, b=1 -> 0x80000000; without it, same stimulus -> 0x00000000 (SRL).
REQ-037 STEP=1, XLEN=64, SLL a=1, b=63 -> 0x8000000000000000 after 64 cycles; back-to-back accept in DONE starts the next op without an IDLE cycle.
